// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over a req/ack memory port,
// and holds one pre-split instruction for the decoder under valid/ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_VALID} state_t;

  localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic [31:0] r_redir;
  logic [31:0] w_redir_tgt;

  assign w_redir_tgt = redirect_pc & PC_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC & PC_MASK;
      r_instr    <= NOP_INSTR;
      r_instr_pc <= RESET_PC & PC_MASK;
      r_redir    <= RESET_PC & PC_MASK;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_REQ;
        S_REQ: begin
          if (redirect_valid && imem_ack) begin
            r_pc <= w_redir_tgt;
          end else if (redirect_valid) begin
            // The in-flight request must finish at its original address first.
            r_redir <= w_redir_tgt;
            r_state <= S_DROP;
          end else if (imem_ack) begin
            r_instr    <= imem_rdata;
            r_instr_pc <= r_pc;
            r_state    <= S_VALID;
          end
        end
        S_DROP: begin
          if (imem_ack) begin
            r_pc    <= redirect_valid ? w_redir_tgt : r_redir;
            r_state <= S_REQ;
          end else if (redirect_valid) begin
            r_redir <= w_redir_tgt;
          end
        end
        S_VALID: begin
          if (redirect_valid) begin
            r_pc    <= w_redir_tgt;
            r_state <= S_REQ;
          end else if (instr_ready) begin
            r_pc    <= r_pc + 32'd4;
            r_state <= S_REQ;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem_addr   = r_pc;
  assign instr_valid = (r_state == S_VALID);
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign opcode      = r_instr[6:0];
  assign rd          = r_instr[11:7];
  assign funct3      = r_instr[14:12];
  assign rs1         = r_instr[19:15];
  assign rs2         = r_instr[24:20];
  assign funct7      = r_instr[31:25];

endmodule
